// File: rtl/ladner_pkg.sv
// ============================================================================
// Module      : ladner_pkg
// Description : Shared types and elaboration helpers for the Ladner-Fischer
//               pipelined prefix adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ladner_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < n) r = k + 1;
    end
    return r;
  endfunction

  function automatic int num_stages(input int width, input int lps);
    return (clog2(width) + lps - 1) / lps;
  endfunction

  // Last bit of the lower half of the 2^(l+1)-aligned block holding bit i.
  function automatic int partner_idx(input int i, input int l);
    return ((i >> l) << l) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ladner_level.sv
// ============================================================================
// Module      : ladner_level
// Description : One combinational Sklansky prefix level (group g/p combine).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ladner_level
  import ladner_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEVEL = 0
) (
  input  gp_t [WIDTH-1:0] gp_i,
  output gp_t [WIDTH-1:0] gp_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (((i >> LEVEL) & 1) == 1) begin : g_op
      localparam int c_J = partner_idx(i, LEVEL);
      assign gp_o[i].g = gp_i[i].g | (gp_i[i].p & gp_i[c_J].g);
      assign gp_o[i].p = gp_i[i].p & gp_i[c_J].p;
    end else begin : g_pass
      assign gp_o[i] = gp_i[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ladner_adder_pipe.sv
// ============================================================================
// Module      : ladner_adder_pipe
// Description : Pipelined Ladner-Fischer prefix adder, sum = a + b + cin, with
//               valid/ready flow control. Define LADNER_OVF_EN for the ovf port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ladner_adder_pipe
  import ladner_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef LADNER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int c_L    = clog2(WIDTH);
  localparam int c_S    = num_stages(WIDTH, LEVELS_PER_STAGE);
  // Register slots: 0 = stage G, 1..c_S = prefix stages, c_S+1 = stage O.
  localparam int c_NREG = c_S + 2;

  logic [c_NREG-1:0] v_q;
  logic [c_NREG-1:0] v_d;
  logic [c_NREG-1:0] w_load;

  gp_t  [WIDTH-1:0]  gp_q      [c_S+1];
  gp_t  [WIDTH-1:0]  w_gp_in;
  gp_t  [WIDTH-1:0]  w_gp_tree [c_S];
  logic [WIDTH-1:0]  porig_q   [c_S+1];
  logic [c_S:0]      cin_q;

  logic [WIDTH-1:0]  w_g_last;
  logic [WIDTH-1:0]  w_unused_p;
  logic [WIDTH-1:0]  w_sum;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;

  // A stage loads when empty or when its successor loads, so bubbles collapse.
  always_comb begin
    logic ld;
    ld = !v_q[c_NREG-1] || out_ready;
    w_load[c_NREG-1] = ld;
    for (int k = c_NREG - 2; k >= 0; k--) begin
      ld = !v_q[k] || ld;
      w_load[k] = ld;
    end
  end

  assign v_d      = {v_q[c_NREG-2:0], in_valid};
  assign in_ready = w_load[0];

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_gp_in[i].g = a[i] & b[i];
      w_gp_in[i].p = a[i] ^ b[i];
    end
    w_gp_in[0].g = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
  end

  for (genvar s = 0; s < c_S; s++) begin : g_stage
    localparam int c_FIRST = s * LEVELS_PER_STAGE;
    localparam int c_NLV   = ((c_L - c_FIRST) < LEVELS_PER_STAGE) ? (c_L - c_FIRST)
                                                                  : LEVELS_PER_STAGE;
    gp_t [WIDTH-1:0] w_lv [c_NLV+1];

    assign w_lv[0] = gp_q[s];
    for (genvar k = 0; k < c_NLV; k++) begin : g_level
      ladner_level #(
        .WIDTH (WIDTH),
        .LEVEL (c_FIRST + k)
      ) u_level (
        .gp_i (w_lv[k]),
        .gp_o (w_lv[k+1])
      );
    end
    assign w_gp_tree[s] = w_lv[c_NLV];
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_g_last[i]   = gp_q[c_S][i].g;
      w_unused_p[i] = gp_q[c_S][i].p;
    end
  end

  assign w_sum = porig_q[c_S] ^ {w_g_last[WIDTH-2:0], cin_q[c_S]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q <= (w_load & v_d) | (~w_load & v_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= c_S; s++) begin
        gp_q[s]    <= '0;
        porig_q[s] <= '0;
      end
      cin_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      if (w_load[0]) begin
        gp_q[0]    <= w_gp_in;
        porig_q[0] <= a ^ b;
        cin_q[0]   <= cin;
      end
      for (int s = 0; s < c_S; s++) begin
        if (w_load[s+1]) begin
          gp_q[s+1]    <= w_gp_tree[s];
          porig_q[s+1] <= porig_q[s];
          cin_q[s+1]   <= cin_q[s];
        end
      end
      if (w_load[c_NREG-1]) begin
        sum_q  <= w_sum;
        cout_q <= w_g_last[WIDTH-1];
      end
    end
  end

  assign out_valid = v_q[c_NREG-1];
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef LADNER_OVF_EN
  logic [c_S:0] sa_q;
  logic [c_S:0] sb_q;
  logic         ovf_q;
  logic         w_ovf;

  assign w_ovf = (sa_q[c_S] == sb_q[c_S]) && (w_sum[WIDTH-1] != sa_q[c_S]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q  <= '0;
      sb_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (w_load[0]) begin
        sa_q[0] <= a[WIDTH-1];
        sb_q[0] <= b[WIDTH-1];
      end
      for (int s = 0; s < c_S; s++) begin
        if (w_load[s+1]) begin
          sa_q[s+1] <= sa_q[s];
          sb_q[s+1] <= sb_q[s];
        end
      end
      if (w_load[c_NREG-1]) ovf_q <= w_ovf;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

`default_nettype wire
